// File: rtl/opp_arb.sv
// opp_arb: first-push arbiter for N player channels.
// Each channel's push level is edge-detected (MODE 0: rising edge, MODE 1:
// any toggle). In IDLE the lowest-index event wins and produces a one-cycle
// winrnd pulse. Every win is followed by a HOLD-cycle lockout during which
// events are discarded.
// Optional feature: define OPP_ARB_TALLY_EN to add saturating per-channel
// win counters on the tally port.
module opp_arb #(
    parameter int N    = 2,
    parameter int MODE = 0,
    parameter int HOLD = 4,
    parameter int TW   = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] sypush,
    output logic [N-1:0] winrnd,
    output logic [2:0]   wid,
    output logic         busy
`ifdef OPP_ARB_TALLY_EN
    ,
    output logic [N*TW-1:0] tally
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WIN,
        S_HOLD
    } state_t;

    state_t       state;
    logic [N-1:0] prev;
    logic [7:0]   lock_cnt;

    logic [N-1:0] ev;
    logic         ev_any;
    logic [N-1:0] first_hot;
    logic [2:0]   first_idx;

    // Event detection against the previous sample.
    assign ev     = (MODE == 0) ? (sypush & ~prev) : (sypush ^ prev);
    assign ev_any = |ev;

    // Lowest-index set bit of ev, as one-hot and as an index.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
        first_hot = '0;
        first_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (ev[i]) begin
                first_hot    = '0;
                first_hot[i] = 1'b1;
                first_idx    = 3'(i);
            end
        end
    end

    // Previous-sample register, tracking in every state so a level still
    // held after lockout does not look like a fresh edge.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (rst) begin
            prev <= '0;
        end else begin
            prev <= sypush;
        end
    end

    // Round FSM with registered winrnd, wid and busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            winrnd   <= '0;
            wid      <= '0;
            busy     <= 1'b0;
            lock_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (ev_any) begin
                        state  <= S_WIN;
                        winrnd <= first_hot;
                        wid    <= first_idx;
                        busy   <= 1'b1;
                    end else begin
                        winrnd <= '0;
                    end
                end
                S_WIN: begin
                    winrnd   <= '0;
                    lock_cnt <= 8'(HOLD - 1);
                    state    <= S_HOLD;
                end
                S_HOLD: begin
                    if (lock_cnt == 8'd0) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        lock_cnt <= lock_cnt - 8'd1;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    winrnd <= '0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

`ifdef OPP_ARB_TALLY_EN
    // Saturating win counters, credited on the edge that enters WIN.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the tally counters are architectural state visible on a port, so they are reset like any other register.
        if (rst) begin
            tally <= '0;
        end else if (state == S_IDLE && ev_any) begin
            for (int i = 0; i < N; i++) begin
                if (first_hot[i] && tally[i*TW +: TW] != {TW{1'b1}}) begin
                    tally[i*TW +: TW] <= tally[i*TW +: TW] + TW'(1);
                end
            end
        end
    end
`endif

endmodule
